dma_xfer: RTL and testbench

DMA_XFER -- requirements
Module: dma_xfer

---
 rtl/dma_xfer_if.sv | 37 +++
 rtl/dma_xfer.sv | 179 +++++++++++++++++
 tb/tb_dma_xfer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_xfer_if.sv
// Memory bus between the DMA engine and the memory it moves data through.
//   o_mem_strobe : one-cycle access request (engine -> memory)
//   o_mem_wrn    : 1 = write, 0 = read
//   o_mem_addr   : access address
//   o_mem_data   : write data
//   i_mem_ready  : one-cycle completion; read data valid in the same cycle
//   i_mem_data   : read data
// The master modport is the DMA side; the slave modport is the memory side.
interface dma_xfer_if #(
  parameter int unsigned DWIDTH = 12,
  parameter int unsigned AWIDTH = 16
);
  logic              o_mem_strobe;
  logic              o_mem_wrn;
  logic [AWIDTH-1:0] o_mem_addr;
  logic [DWIDTH-1:0] o_mem_data;
  logic              i_mem_ready;
  logic [DWIDTH-1:0] i_mem_data;

  modport master (
    output o_mem_strobe,
    output o_mem_wrn,
    output o_mem_addr,
    output o_mem_data,
    input  i_mem_ready,
    input  i_mem_data
  );

  modport slave (
    input  o_mem_strobe,
    input  o_mem_wrn,
    input  o_mem_addr,
    input  o_mem_data,
    output i_mem_ready,
    output i_mem_data
  );
endinterface

// File: rtl/dma_xfer.sv
// Single-channel DMA engine: copies a block ascending or descending, or fills a block
// with a constant pattern, one word at a time over a strobe/ready memory bus.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_src_addr/i_dst_addr/i_len/i_mode/i_fill_data : command, latched on i_go in IDLE
//   i_go                : start request (ignored while busy)
//   o_busy              : engine not idle
//   o_done / o_err      : one-cycle completion pulse / error qualifier on that pulse
//   mem                 : memory bus (master side)
module dma_xfer #(
  parameter int unsigned DWIDTH  = 12,
  parameter int unsigned AWIDTH  = 16,
  parameter int unsigned LWIDTH  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [AWIDTH-1:0] i_src_addr,
  input  logic [AWIDTH-1:0] i_dst_addr,
  input  logic [LWIDTH-1:0] i_len,
  input  logic [1:0]        i_mode,
  input  logic [DWIDTH-1:0] i_fill_data,
  input  logic              i_go,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  dma_xfer_if.master        mem
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_CMD,
    READ_WAIT,
    WRITE_CMD,
    WRITE_WAIT,
    NEXT
  } state_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_src;
  logic [AWIDTH-1:0] r_dst;
  logic [LWIDTH-1:0] r_rem;
  logic              r_desc;
  logic              r_fill;
  logic [DWIDTH-1:0] r_fill_data;
  logic [WW-1:0]     r_wait;
  logic              r_done;
  logic              r_err;
  logic              r_strobe;
  logic              r_wrn;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_data;

  logic [AWIDTH-1:0] w_src_nxt;
  logic [AWIDTH-1:0] w_dst_nxt;
  logic              w_timeout;

  // Address stepping wraps naturally modulo 2^AWIDTH.
  assign w_src_nxt = r_desc ? r_src - AWIDTH'(1) : r_src + AWIDTH'(1);
  assign w_dst_nxt = r_desc ? r_dst - AWIDTH'(1) : r_dst + AWIDTH'(1);
  assign w_timeout = (r_wait == WW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_rem       <= '0;
      r_desc      <= 1'b0;
      r_fill      <= 1'b0;
      r_fill_data <= '0;
      r_wait      <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_strobe    <= 1'b0;
      r_wrn       <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_strobe <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_go) begin
            r_src       <= i_src_addr;
            r_dst       <= i_dst_addr;
            r_rem       <= i_len;
            r_desc      <= (i_mode == 2'b01);
            r_fill      <= (i_mode == 2'b10);
            r_fill_data <= i_fill_data;
            if (i_len == '0 || i_mode == 2'b11) begin
              r_done <= 1'b1;
              r_err  <= (i_mode == 2'b11);
            end else if (i_mode == 2'b10) begin
              r_state  <= WRITE_CMD;
              r_strobe <= 1'b1;
              r_wrn    <= 1'b1;
              r_addr   <= i_dst_addr;
              r_data   <= i_fill_data;
            end else begin
              r_state  <= READ_CMD;
              r_strobe <= 1'b1;
              r_wrn    <= 1'b0;
              r_addr   <= i_src_addr;
            end
          end
        end
        READ_CMD: begin
          r_state <= READ_WAIT;
          r_wait  <= '0;
        end
        READ_WAIT: begin
          if (mem.i_mem_ready) begin
            // Captured read word goes straight onto the write bus.
            r_state  <= WRITE_CMD;
            r_strobe <= 1'b1;
            r_wrn    <= 1'b1;
            r_addr   <= r_dst;
            r_data   <= mem.i_mem_data;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        WRITE_CMD: begin
          r_state <= WRITE_WAIT;
          r_wait  <= '0;
        end
        WRITE_WAIT: begin
          if (mem.i_mem_ready) begin
            r_state <= NEXT;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        NEXT: begin
          r_rem <= r_rem - LWIDTH'(1);
          r_src <= w_src_nxt;
          r_dst <= w_dst_nxt;
          if (r_rem == LWIDTH'(1)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (r_fill) begin
            r_state  <= WRITE_CMD;
            r_strobe <= 1'b1;
            r_wrn    <= 1'b1;
            r_addr   <= w_dst_nxt;
            r_data   <= r_fill_data;
          end else begin
            r_state  <= READ_CMD;
            r_strobe <= 1'b1;
            r_wrn    <= 1'b0;
            r_addr   <= w_src_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy           = (r_state != IDLE);
  assign o_done           = r_done;
  assign o_err            = r_err;
  assign mem.o_mem_strobe = r_strobe;
  assign mem.o_mem_wrn    = r_wrn;
  assign mem.o_mem_addr   = r_addr;
  assign mem.o_mem_data   = r_data;

endmodule

// File: tb/tb_dma_xfer.sv
// Randomized bench for dma_xfer: a transaction-level model predicts the ordered list of
// memory accesses and the cycle timing of strobes and completion; one per-cycle compare
// step checks every output against it. Directed runs pin the model with literal values.
module tb_dma_xfer;
  localparam int unsigned DW = 12;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 16;
  localparam int unsigned TO = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [AW-1:0] i_src_addr;
  logic [AW-1:0] i_dst_addr;
  logic [LW-1:0] i_len;
  logic [1:0]    i_mode;
  logic [DW-1:0] i_fill_data;
  logic          i_go;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  dma_xfer_if #(.DWIDTH(DW), .AWIDTH(AW)) mem_if ();

  dma_xfer #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW), .TIMEOUT(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_src_addr  (i_src_addr),
    .i_dst_addr  (i_dst_addr),
    .i_len       (i_len),
    .i_mode      (i_mode),
    .i_fill_data (i_fill_data),
    .i_go        (i_go),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .mem         (mem_if)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic          wrn;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  acc_t          exp_q[$];
  acc_t          cur;
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  int  cyc, go_cyc, exp_strobe, exp_done, ready_cyc, cur_strobe_cyc;
  int  first_strobe, done_cyc, rst_word, rst_cyc, fixed_d, rd_count;
  bit  exp_err, op_real, never_ready, rst_prev, rst_hit, cur_active, last_err;
  int  n_cmp, n_fail;

  // Memory contents as seen by reads.
  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return DW'(a) ^ 12'h5A5;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic step();
    bit exp_busy;
    exp_busy = 1'b0;
    @(negedge i_clk);
    cyc++;
    i_rst = 1'b0;
    i_go  = 1'b0;
    mem_if.i_mem_ready = 1'b0;
    mem_if.i_mem_data  = DW'($urandom);
    if (rst_prev) begin
      rst_prev = 1'b0;
      chk("rst_busy", 64'(o_busy), 0);
      chk("rst_done", 64'(o_done), 0);
      chk("rst_err", 64'(o_err), 0);
      chk("rst_strobe", 64'(mem_if.o_mem_strobe), 0);
      chk("rst_wrn", 64'(mem_if.o_mem_wrn), 0);
      chk("rst_addr", 64'(mem_if.o_mem_addr), 0);
      chk("rst_data", 64'(mem_if.o_mem_data), 0);
    end else begin
      exp_busy = op_real && cyc > go_cyc && (exp_done < 0 || cyc < exp_done);
      chk("busy", 64'(o_busy), 64'(exp_busy));
      chk("done", 64'(o_done), 64'(cyc == exp_done));
      chk("err", 64'(o_err), 64'(cyc == exp_done && exp_err));
      chk("strobe", 64'(mem_if.o_mem_strobe), 64'(cyc == exp_strobe));
      if (mem_if.o_mem_strobe && cyc == exp_strobe) begin
        if (exp_q.size() == 0) begin
          chk("extra_access", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("acc_wrn", 64'(mem_if.o_mem_wrn), 64'(cur.wrn));
          chk("acc_addr", 64'(mem_if.o_mem_addr), 64'(cur.addr));
          if (cur.wrn) begin
            chk("acc_data", 64'(mem_if.o_mem_data), 64'(cur.data));
            wr_addr_log.push_back(mem_if.o_mem_addr);
            wr_data_log.push_back(mem_if.o_mem_data);
            if (rst_word > 0 && wr_addr_log.size() == rst_word) rst_cyc = cyc + 2;
          end else begin
            rd_count++;
          end
          if (first_strobe < 0) first_strobe = cyc;
          cur_active     = 1'b1;
          cur_strobe_cyc = cyc;
          if (never_ready) begin
            ready_cyc = -1;
            exp_done  = cyc + 1 + int'(TO);
            exp_err   = 1'b1;
          end else begin
            ready_cyc = cyc + ((fixed_d > 0) ? fixed_d : int'($urandom_range(1, 6)));
          end
        end
      end else if (cur_active) begin
        chk("hold_wrn", 64'(mem_if.o_mem_wrn), 64'(cur.wrn));
        chk("hold_addr", 64'(mem_if.o_mem_addr), 64'(cur.addr));
        if (cur.wrn) chk("hold_data", 64'(mem_if.o_mem_data), 64'(cur.data));
      end
      if (cyc == exp_done) begin
        op_real    = 1'b0;
        cur_active = 1'b0;
        done_cyc   = cyc;
        last_err   = o_err;
      end
    end
    // Drive inputs for this cycle.
    if (cyc == rst_cyc) begin
      i_rst      = 1'b1;
      rst_prev   = 1'b1;
      rst_hit    = 1'b1;
      op_real    = 1'b0;
      cur_active = 1'b0;
      exp_q.delete();
      exp_strobe = -1;
      exp_done   = -1;
      rst_cyc    = -1;
    end else if (cur_active && cyc == ready_cyc) begin
      mem_if.i_mem_ready = 1'b1;
      cur_active = 1'b0;
      if (!cur.wrn) begin
        mem_if.i_mem_data = rd_val(cur.addr);
        exp_strobe = cyc + 1;
      end else if (exp_q.size() == 0) begin
        exp_done = cyc + 2;
        exp_err  = 1'b0;
      end else begin
        exp_strobe = cyc + 2;
      end
    end else if (((cur_active && cyc == cur_strobe_cyc) || !op_real) && $urandom_range(0, 3) == 0) begin
      // Stray ready while in a command state or idle must be ignored.
      mem_if.i_mem_ready = 1'b1;
    end
    if (exp_busy && $urandom_range(0, 4) == 0) begin
      // Stray start and changing command inputs while busy must be ignored.
      i_go        = 1'b1;
      i_src_addr  = AW'($urandom);
      i_dst_addr  = AW'($urandom);
      i_len       = LW'($urandom);
      i_mode      = 2'($urandom);
      i_fill_data = DW'($urandom);
    end
  endtask

  task automatic run_cmd(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len,
                         input logic [1:0] mode, input logic [DW-1:0] fill, input bit never,
                         input int fd, input int rword);
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    never_ready = never;
    fixed_d     = fd;
    rst_word    = rword;
    rst_hit     = 1'b0;
    exp_q.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_count     = 0;
    first_strobe = -1;
    done_cyc     = -1;
    last_err     = 1'b0;
    if (mode != 2'b11) begin
      for (int i = 0; i < len; i++) begin
        s = (mode == 2'b01) ? src - AW'(i) : src + AW'(i);
        d = (mode == 2'b01) ? dst - AW'(i) : dst + AW'(i);
        if (mode != 2'b10) exp_q.push_back('{wrn: 1'b0, addr: s, data: '0});
        if (never) break;
        exp_q.push_back('{wrn: 1'b1, addr: d, data: (mode == 2'b10) ? fill : rd_val(s)});
      end
    end
    i_src_addr  = src;
    i_dst_addr  = dst;
    i_len       = LW'(len);
    i_mode      = mode;
    i_fill_data = fill;
    i_go        = 1'b1;
    go_cyc      = cyc;
    op_real     = (len != 0 && mode != 2'b11);
    if (op_real) begin
      exp_strobe = cyc + 1;
      exp_done   = -1;
    end else begin
      exp_strobe = -1;
      exp_done   = cyc + 1;
      exp_err    = (mode == 2'b11);
    end
    for (int k = 0; k < 600 && done_cyc < 0 && !rst_hit; k++) step();
    if (done_cyc < 0 && !rst_hit) chk("op_finished", 0, 1);
    chk("leftover_accesses", 64'(exp_q.size()), 0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    exp_strobe = -1; exp_done = -1; ready_cyc = -1; rst_cyc = -1; rst_word = 0;
    go_cyc = 0; op_real = 1'b0; cur_active = 1'b0; cur_strobe_cyc = -1;
    i_rst = 1'b1; rst_prev = 1'b1; i_go = 1'b0;
    i_src_addr = '0; i_dst_addr = '0; i_len = '0; i_mode = '0; i_fill_data = '0;
    mem_if.i_mem_ready = 1'b0; mem_if.i_mem_data = '0;
    step();
    repeat (2) step();

    // Ascending copy, ready two cycles after each strobe: 7 cycles per word.
    run_cmd(16'h0010, 16'h0080, 3, 2'b00, 12'h000, 1'b0, 2, 0);
    chk("cp_reads", 64'(rd_count), 3);
    chk("cp_nwr", 64'(wr_addr_log.size()), 3);
    if (wr_addr_log.size() == 3) begin
      chk("cp_wa0", 64'(wr_addr_log[0]), 64'h80);
      chk("cp_wa2", 64'(wr_addr_log[2]), 64'h82);
      chk("cp_wd0", 64'(wr_data_log[0]), 64'h5B5);
      chk("cp_wd1", 64'(wr_data_log[1]), 64'h5B4);
      chk("cp_wd2", 64'(wr_data_log[2]), 64'h5B7);
    end
    chk("cp_latency", 64'(done_cyc - go_cyc), 22);
    chk("cp_err", 64'(last_err), 0);

    // Descending copy with destination wrapping below zero.
    run_cmd(16'h0002, 16'h0001, 3, 2'b01, 12'h000, 1'b0, 0, 0);
    chk("dsc_reads", 64'(rd_count), 3);
    chk("dsc_nwr", 64'(wr_addr_log.size()), 3);
    if (wr_addr_log.size() == 3) begin
      chk("dsc_wa0", 64'(wr_addr_log[0]), 64'h0001);
      chk("dsc_wa1", 64'(wr_addr_log[1]), 64'h0000);
      chk("dsc_wa2", 64'(wr_addr_log[2]), 64'hFFFF);
      chk("dsc_wd2", 64'(wr_data_log[2]), 64'h5A5);
    end

    // Fill: no reads, ready two cycles after strobe: 4 cycles per word.
    run_cmd(16'h1234, 16'h0040, 4, 2'b10, 12'hABC, 1'b0, 2, 0);
    chk("fill_reads", 64'(rd_count), 0);
    chk("fill_nwr", 64'(wr_addr_log.size()), 4);
    if (wr_addr_log.size() == 4) begin
      chk("fill_wa3", 64'(wr_addr_log[3]), 64'h43);
      chk("fill_wd3", 64'(wr_data_log[3]), 64'hABC);
    end
    chk("fill_latency", 64'(done_cyc - go_cyc), 17);

    // Zero length and reserved mode complete on the next cycle.
    run_cmd(16'h0005, 16'h0006, 0, 2'b00, 12'h000, 1'b0, 0, 0);
    chk("zero_latency", 64'(done_cyc - go_cyc), 1);
    chk("zero_err", 64'(last_err), 0);
    run_cmd(16'h0005, 16'h0006, 3, 2'b11, 12'h000, 1'b0, 0, 0);
    chk("rsv_latency", 64'(done_cyc - go_cyc), 1);
    chk("rsv_err", 64'(last_err), 1);

    // Timeout: memory never answers.
    run_cmd(16'h0100, 16'h0200, 2, 2'b00, 12'h000, 1'b1, 0, 0);
    chk("to_latency", 64'(done_cyc - first_strobe), 64'(1 + TO));
    chk("to_err", 64'(last_err), 1);
    repeat (3) step();

    // Reset during the second write of four, then a normal run.
    run_cmd(16'h0000, 16'h0300, 4, 2'b10, 12'h123, 1'b0, 5, 2);
    chk("rst_hit", 64'(rst_hit), 1);
    rst_word = 0;
    repeat (4) step();
    run_cmd(16'h0700, 16'h0900, 2, 2'b00, 12'h000, 1'b0, 0, 0);
    chk("post_rst_nwr", 64'(wr_addr_log.size()), 2);

    // Random commands, back to back, random latencies and stray inputs.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] m;
      m = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_cmd(AW'($urandom), AW'($urandom), int'($urandom_range(0, 5)), m, DW'($urandom),
              1'b0, 0, 0);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

endmodule
